id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- ID/EX pipeline register of the 16-bit, 4-GPR pipelined TSC core; captures decoded operands, register indices and control from ID and presents them to EX.
- rs_ex, rt_ex and operand data feed the EX-stage forwarding logic and operand muxes directly.
- Supports stall (hold), flush (bubble insertion) and a WB write-through bypass, so EX never holds an operand the register file has already overwritten.

Parameters:
- WORD_SIZE, 16, datapath width of PC, operands and immediate.
- CTRL_WIDTH, 8, width of the opaque EX/MEM/WB control bundle.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold all ID/EX contents this cycle.
- flush  input  1  replace ID/EX contents with a bubble (branch/jump resolved in EX).
- valid_id  input  1  ID holds a real instruction.
- pc_id  input  WORD_SIZE  PC of ID instruction.
- rs_id, rt_id, rd_id  input  2 each  register indices from decode.
- rs_data_id, rt_data_id  input  WORD_SIZE each  register file read data.
- imm_id  input  WORD_SIZE  sign/zero-extended immediate.
- ctrl_id  input  CTRL_WIDTH  control bundle.
- mem_read_id, mem_write_id, reg_write_id  input  1 each  side-effecting controls.
- reg_write_wb  input  1  WB stage writes the register file this cycle.
- write_reg_wb  input  2  WB destination index.
- write_data_wb  input  WORD_SIZE  WB write data.
- valid_ex, pc_ex, rs_ex, rt_ex, rd_ex, rs_data_ex, rt_data_ex, imm_ex, ctrl_ex, mem_read_ex, mem_write_ex, reg_write_ex  output  widths as the ID counterparts  registered EX-side copies.
- bubble_count  output  16  bubbles inserted (optional feature).
- stall_count  output  16  stall cycles (optional feature).

Behaviour:
- Reset (asynchronous, immediate): every output is 0, including counters. This gives valid_ex=0 and all side-effect controls 0, so the stage is a bubble.
- Latency: exactly 1 cycle from ID inputs to EX outputs when not stalled.
- Priority per rising edge: reset > flush > stall > load.
- Flush: valid_ex, mem_read_ex, mem_write_ex, reg_write_ex and ctrl_ex become 0. Other fields are don't-care; they are driven to 0.
- Flush together with stall: flush wins and the stage becomes a bubble.
- Stall (no flush): all fields hold, except the write-through refresh below.
- Load (no stall, no flush): all fields take the ID values.
- valid_id=0 on a load produces a bubble identical to a flush bubble.
- Write-through on load: if reg_write_wb and write_reg_wb==rs_id, then rs_data_ex takes write_data_wb instead of rs_data_id. The same rule applies independently to rt; both may match.
- Write-through on stall: if valid_ex and reg_write_wb and write_reg_wb==rs_ex, then rs_data_ex is refreshed to write_data_wb. The same rule applies to rt. This prevents stale operands when the producer retires during the hold.
- No write-through on flush or into a bubble.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_count increments on every edge that loads a bubble, by flush or by valid_id=0.
  - stall_count increments on every edge with stall=1 and flush=0.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: no counter flops; both outputs are tied to 16'h0000.

Test Plan:
- Reset asserted mid-stream with valid_ex=1, reg_write_ex=1 -> all outputs 0 immediately, without waiting for clk; stay 0 until the first load after deassert.
- Load valid_id=1, pc_id=16'h0010, rs_id=1, rt_id=2, rs_data_id=16'h1111, rt_data_id=16'h2222, reg_write_id=1 -> next edge: valid_ex=1, rs_ex=1, rt_ex=2, rs_data_ex=16'h1111, rt_data_ex=16'h2222, pc_ex=16'h0010.
- Load with rs_id=rt_id=3, rs_data_id=rt_data_id=16'hAAAA, reg_write_wb=1, write_reg_wb=3, write_data_wb=16'h5555 -> rs_data_ex=rt_data_ex=16'h5555.
- Hold stall=1 for 2 cycles with rs_ex=1, rs_data_ex=16'h1111; in cycle 2 drive reg_write_wb=1, write_reg_wb=1, write_data_wb=16'h7777 -> other fields unchanged, rs_data_ex becomes 16'h7777; with PERF_CNT, stall_count=2.
- flush=1 and stall=1 together with valid_ex=1, mem_write_ex=1 -> next edge valid_ex=0, mem_write_ex=0, ctrl_ex=0; with PERF_CNT, bubble_count+1 and stall_count unchanged.
- Counter saturation (ID_EX_PERF_CNT_EN defined): 65536 consecutive flush cycles -> bubble_count=16'hFFFF and holds there.

Source files
------------

// File: rtl/id_ex_register_if.sv
// ID/EX stage bundle: ID-side capture inputs, WB write-through inputs and the
// registered EX-side outputs of the ID/EX pipeline register.
interface id_ex_register_if #(
  parameter int WORD_SIZE  = 16,
  parameter int CTRL_WIDTH = 8
);
  logic                  stall;
  logic                  flush;
  logic                  valid_id;
  logic [WORD_SIZE-1:0]  pc_id;
  logic [1:0]            rs_id;
  logic [1:0]            rt_id;
  logic [1:0]            rd_id;
  logic [WORD_SIZE-1:0]  rs_data_id;
  logic [WORD_SIZE-1:0]  rt_data_id;
  logic [WORD_SIZE-1:0]  imm_id;
  logic [CTRL_WIDTH-1:0] ctrl_id;
  logic                  mem_read_id;
  logic                  mem_write_id;
  logic                  reg_write_id;
  logic                  reg_write_wb;
  logic [1:0]            write_reg_wb;
  logic [WORD_SIZE-1:0]  write_data_wb;

  logic                  valid_ex;
  logic [WORD_SIZE-1:0]  pc_ex;
  logic [1:0]            rs_ex;
  logic [1:0]            rt_ex;
  logic [1:0]            rd_ex;
  logic [WORD_SIZE-1:0]  rs_data_ex;
  logic [WORD_SIZE-1:0]  rt_data_ex;
  logic [WORD_SIZE-1:0]  imm_ex;
  logic [CTRL_WIDTH-1:0] ctrl_ex;
  logic                  mem_read_ex;
  logic                  mem_write_ex;
  logic                  reg_write_ex;
  logic [15:0]           bubble_count;
  logic [15:0]           stall_count;

  modport slave (
    input  stall, flush, valid_id, pc_id, rs_id, rt_id, rd_id,
           rs_data_id, rt_data_id, imm_id, ctrl_id,
           mem_read_id, mem_write_id, reg_write_id,
           reg_write_wb, write_reg_wb, write_data_wb,
    output valid_ex, pc_ex, rs_ex, rt_ex, rd_ex, rs_data_ex, rt_data_ex,
           imm_ex, ctrl_ex, mem_read_ex, mem_write_ex, reg_write_ex,
           bubble_count, stall_count
  );

  modport master (
    output stall, flush, valid_id, pc_id, rs_id, rt_id, rd_id,
           rs_data_id, rt_data_id, imm_id, ctrl_id,
           mem_read_id, mem_write_id, reg_write_id,
           reg_write_wb, write_reg_wb, write_data_wb,
    input  valid_ex, pc_ex, rs_ex, rt_ex, rd_ex, rs_data_ex, rt_data_ex,
           imm_ex, ctrl_ex, mem_read_ex, mem_write_ex, reg_write_ex,
           bubble_count, stall_count
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush and WB write-through bypass.
// Optional bubble/stall performance counters are enabled by ID_EX_PERF_CNT_EN.
module id_ex_register #(
  parameter int WORD_SIZE  = 16,
  parameter int CTRL_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  id_ex_register_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [WORD_SIZE-1:0]  pc;
    logic [1:0]            rs;
    logic [1:0]            rt;
    logic [1:0]            rd;
    logic [WORD_SIZE-1:0]  rs_data;
    logic [WORD_SIZE-1:0]  rt_data;
    logic [WORD_SIZE-1:0]  imm;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } ex_stage_t;

  ex_stage_t ex_q;
  ex_stage_t ex_next;

  // Priority: flush > stall > load; a load of an invalid ID slot is a bubble.
  always_comb begin
    // NOTE: hold is the default so every path assigns ex_next and no latch is inferred.
    ex_next = ex_q;
    if (bus.flush) begin
      ex_next = '0;
    end else if (bus.stall) begin
      // Refresh held operands when their producer retires during the stall.
      if (ex_q.valid && bus.reg_write_wb) begin
        if (bus.write_reg_wb == ex_q.rs) ex_next.rs_data = bus.write_data_wb;
        if (bus.write_reg_wb == ex_q.rt) ex_next.rt_data = bus.write_data_wb;
      end
    end else if (!bus.valid_id) begin
      ex_next = '0;
    end else begin
      ex_next.valid     = 1'b1;
      ex_next.pc        = bus.pc_id;
      ex_next.rs        = bus.rs_id;
      ex_next.rt        = bus.rt_id;
      ex_next.rd        = bus.rd_id;
      ex_next.imm       = bus.imm_id;
      ex_next.ctrl      = bus.ctrl_id;
      ex_next.mem_read  = bus.mem_read_id;
      ex_next.mem_write = bus.mem_write_id;
      ex_next.reg_write = bus.reg_write_id;
      ex_next.rs_data   = (bus.reg_write_wb && bus.write_reg_wb == bus.rs_id)
                          ? bus.write_data_wb : bus.rs_data_id;
      ex_next.rt_data   = (bus.reg_write_wb && bus.write_reg_wb == bus.rt_id)
                          ? bus.write_data_wb : bus.rt_data_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) ex_q <= '0;
    else       ex_q <= ex_next;
  end

  assign bus.valid_ex     = ex_q.valid;
  assign bus.pc_ex        = ex_q.pc;
  assign bus.rs_ex        = ex_q.rs;
  assign bus.rt_ex        = ex_q.rt;
  assign bus.rd_ex        = ex_q.rd;
  assign bus.rs_data_ex   = ex_q.rs_data;
  assign bus.rt_data_ex   = ex_q.rt_data;
  assign bus.imm_ex       = ex_q.imm;
  assign bus.ctrl_ex      = ex_q.ctrl;
  assign bus.mem_read_ex  = ex_q.mem_read;
  assign bus.mem_write_ex = ex_q.mem_write;
  assign bus.reg_write_ex = ex_q.reg_write;

`ifdef ID_EX_PERF_CNT_EN
  logic        bubble_load;
  logic [15:0] bubble_q;
  logic [15:0] stall_q;

  assign bubble_load = bus.flush || (!bus.stall && !bus.valid_id);

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (bubble_load && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      if (bus.stall && !bus.flush && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.bubble_count = bubble_q;
  assign bus.stall_count  = stall_q;
`else
  assign bus.bubble_count = 16'h0000;
  assign bus.stall_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: per-cycle model comparison plus
// directed vectors with hand-computed expectations.
module tb_id_ex_register;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_register_if #(.WORD_SIZE(16), .CTRL_WIDTH(8)) bus ();

  id_ex_register #(.WORD_SIZE(16), .CTRL_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: what EX must hold, straight from the stage rules.
  logic        m_valid = 0, m_mr = 0, m_mw = 0, m_rw = 0;
  logic [15:0] m_pc = 0, m_rsd = 0, m_rtd = 0, m_imm = 0;
  logic [1:0]  m_rs = 0, m_rt = 0, m_rd = 0;
  logic [7:0]  m_ctrl = 0;
  int          m_bubbles = 0, m_stalls = 0;

  function automatic logic [15:0] operand(input logic [1:0] idx, input logic [15:0] rf_value);
    if (bus.reg_write_wb && bus.write_reg_wb == idx) return bus.write_data_wb;
    return rf_value;
  endfunction

  task automatic model_bubble();
    {m_valid, m_mr, m_mw, m_rw} = '0;
    {m_pc, m_rsd, m_rtd, m_imm} = '0;
    {m_rs, m_rt, m_rd} = '0;
    m_ctrl = '0;
    if (m_bubbles < 65535) m_bubbles++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {m_valid, m_mr, m_mw, m_rw} = '0;
      {m_pc, m_rsd, m_rtd, m_imm} = '0;
      {m_rs, m_rt, m_rd} = '0;
      m_ctrl = '0;
      m_bubbles = 0;
      m_stalls = 0;
    end else if (bus.flush) begin
      model_bubble();
    end else if (bus.stall) begin
      if (m_stalls < 65535) m_stalls++;
      if (m_valid) begin
        m_rsd = operand(m_rs, m_rsd);
        m_rtd = operand(m_rt, m_rtd);
      end
    end else if (!bus.valid_id) begin
      model_bubble();
    end else begin
      m_valid = 1'b1;
      m_pc = bus.pc_id; m_imm = bus.imm_id; m_ctrl = bus.ctrl_id;
      m_rs = bus.rs_id; m_rt = bus.rt_id; m_rd = bus.rd_id;
      m_rsd = operand(bus.rs_id, bus.rs_data_id);
      m_rtd = operand(bus.rt_id, bus.rt_data_id);
      m_mr = bus.mem_read_id; m_mw = bus.mem_write_id; m_rw = bus.reg_write_id;
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_valid_ex",     32'(bus.valid_ex),     32'(m_valid));
    check("cmp_pc_ex",        32'(bus.pc_ex),        32'(m_pc));
    check("cmp_rs_ex",        32'(bus.rs_ex),        32'(m_rs));
    check("cmp_rt_ex",        32'(bus.rt_ex),        32'(m_rt));
    check("cmp_rd_ex",        32'(bus.rd_ex),        32'(m_rd));
    check("cmp_rs_data_ex",   32'(bus.rs_data_ex),   32'(m_rsd));
    check("cmp_rt_data_ex",   32'(bus.rt_data_ex),   32'(m_rtd));
    check("cmp_imm_ex",       32'(bus.imm_ex),       32'(m_imm));
    check("cmp_ctrl_ex",      32'(bus.ctrl_ex),      32'(m_ctrl));
    check("cmp_mem_read_ex",  32'(bus.mem_read_ex),  32'(m_mr));
    check("cmp_mem_write_ex", 32'(bus.mem_write_ex), 32'(m_mw));
    check("cmp_reg_write_ex", 32'(bus.reg_write_ex), 32'(m_rw));
    check("cmp_bubble_count", 32'(bus.bubble_count), PERF ? 32'(m_bubbles) : 32'd0);
    check("cmp_stall_count",  32'(bus.stall_count),  PERF ? 32'(m_stalls)  : 32'd0);
  end

  task automatic set_id(input logic v, input logic [15:0] pc, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [1:0] rd, input logic [15:0] rsd,
                        input logic [15:0] rtd, input logic [15:0] imm, input logic [7:0] ctrl,
                        input logic mr, input logic mw, input logic rw);
    bus.valid_id = v; bus.pc_id = pc; bus.rs_id = rs; bus.rt_id = rt; bus.rd_id = rd;
    bus.rs_data_id = rsd; bus.rt_data_id = rtd; bus.imm_id = imm; bus.ctrl_id = ctrl;
    bus.mem_read_id = mr; bus.mem_write_id = mw; bus.reg_write_id = rw;
  endtask

  task automatic set_wb(input logic en, input logic [1:0] idx, input logic [15:0] data);
    bus.reg_write_wb = en; bus.write_reg_wb = idx; bus.write_data_wb = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 8'h0, 0, 0, 0);
    set_wb(0, 0, 16'h0);
    step();
    step();
    check("reset_valid_ex", 32'(bus.valid_ex), 32'd0);
    check("reset_pc_ex",    32'(bus.pc_ex),    32'd0);

    // Plain load.
    reset = 1'b0;
    set_id(1, 16'h0010, 1, 2, 3, 16'h1111, 16'h2222, 16'h0042, 8'hA5, 0, 0, 1);
    step();
    check("load_valid_ex",   32'(bus.valid_ex),   32'd1);
    check("load_rs_ex",      32'(bus.rs_ex),      32'd1);
    check("load_rt_ex",      32'(bus.rt_ex),      32'd2);
    check("load_rs_data_ex", 32'(bus.rs_data_ex), 32'h1111);
    check("load_rt_data_ex", 32'(bus.rt_data_ex), 32'h2222);
    check("load_pc_ex",      32'(bus.pc_ex),      32'h0010);

    // Two-cycle stall, WB retires r1 in the second cycle.
    bus.stall = 1'b1;
    set_id(1, 16'h0099, 2, 3, 0, 16'hDEAD, 16'hBEEF, 16'h0007, 8'h11, 1, 1, 0);
    step();
    check("stall1_rs_data_ex", 32'(bus.rs_data_ex), 32'h1111);
    check("stall1_pc_ex",      32'(bus.pc_ex),      32'h0010);
    set_wb(1, 1, 16'h7777);
    step();
    check("stall2_rs_data_ex", 32'(bus.rs_data_ex), 32'h7777);
    check("stall2_rt_data_ex", 32'(bus.rt_data_ex), 32'h2222);
    check("stall2_pc_ex",      32'(bus.pc_ex),      32'h0010);
    check("stall2_imm_ex",     32'(bus.imm_ex),     32'h0042);
    if (PERF) check("stall2_stall_count", 32'(bus.stall_count), 32'd2);

    // Flush together with stall on a valid store.
    bus.stall = 1'b0;
    set_wb(0, 0, 16'h0);
    set_id(1, 16'h0020, 1, 2, 3, 16'h0101, 16'h0202, 16'h0003, 8'h3C, 0, 1, 0);
    step();
    check("store_mem_write_ex", 32'(bus.mem_write_ex), 32'd1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    check("flush_valid_ex",     32'(bus.valid_ex),     32'd0);
    check("flush_mem_write_ex", 32'(bus.mem_write_ex), 32'd0);
    check("flush_ctrl_ex",      32'(bus.ctrl_ex),      32'd0);
    if (PERF) begin
      check("flush_bubble_count", 32'(bus.bubble_count), 32'd1);
      check("flush_stall_count",  32'(bus.stall_count),  32'd2);
    end

    // Write-through on load: both, one, and neither operand matching.
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1, 16'h0030, 3, 3, 0, 16'hAAAA, 16'hAAAA, 16'h0000, 8'h01, 0, 0, 1);
    set_wb(1, 3, 16'h5555);
    step();
    check("wt_both_rs_data_ex", 32'(bus.rs_data_ex), 32'h5555);
    check("wt_both_rt_data_ex", 32'(bus.rt_data_ex), 32'h5555);
    set_id(1, 16'h0032, 2, 1, 0, 16'h0BAD, 16'h0C0D, 16'h0000, 8'h02, 1, 0, 0);
    set_wb(1, 1, 16'h1234);
    step();
    check("wt_rt_rs_data_ex", 32'(bus.rs_data_ex), 32'h0BAD);
    check("wt_rt_rt_data_ex", 32'(bus.rt_data_ex), 32'h1234);
    set_wb(0, 2, 16'hFFFF);
    step();
    check("wt_off_rs_data_ex", 32'(bus.rs_data_ex), 32'h0BAD);

    // valid_id=0 load is a bubble; no write-through into it.
    set_id(0, 16'h0040, 1, 1, 2, 16'h9999, 16'h9999, 16'h00FF, 8'hFF, 1, 1, 1);
    set_wb(1, 1, 16'h4444);
    step();
    check("idle_valid_ex",     32'(bus.valid_ex),     32'd0);
    check("idle_rs_data_ex",   32'(bus.rs_data_ex),   32'd0);
    check("idle_reg_write_ex", 32'(bus.reg_write_ex), 32'd0);
    if (PERF) check("idle_bubble_count", 32'(bus.bubble_count), 32'd2);
    bus.stall = 1'b1;
    set_wb(1, 0, 16'h6666);
    step();
    check("stall_bubble_rs_data_ex", 32'(bus.rs_data_ex), 32'd0);

    // Asynchronous reset in the middle of a valid instruction.
    bus.stall = 1'b0;
    set_wb(0, 0, 16'h0);
    set_id(1, 16'h0050, 1, 2, 3, 16'h1010, 16'h2020, 16'h0005, 8'h81, 0, 0, 1);
    step();
    check("pre_reset_reg_write_ex", 32'(bus.reg_write_ex), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_valid_ex",     32'(bus.valid_ex),     32'd0);
    check("async_reset_reg_write_ex", 32'(bus.reg_write_ex), 32'd0);
    check("async_reset_bubble_count", 32'(bus.bubble_count), 32'd0);
    step();
    check("held_reset_valid_ex", 32'(bus.valid_ex), 32'd0);
    reset = 1'b0;
    step();
    check("post_reset_valid_ex", 32'(bus.valid_ex), 32'd1);
    check("post_reset_pc_ex",    32'(bus.pc_ex),    32'h0050);

`ifdef ID_EX_PERF_CNT_EN
    // Bubble counter saturation.
    bus.flush = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("sat_bubble_count", 32'(bus.bubble_count), 32'hFFFF);
    step();
    step();
    check("sat_hold_bubble_count", 32'(bus.bubble_count), 32'hFFFF);
    check("sat_stall_count",       32'(bus.stall_count),  32'd0);
    bus.flush = 1'b0;
`endif

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
